// File: rtl/cpu_cs_useq_16.sv
// Control-store micro-sequencer: next-address select, return stack and loop counter.
// Optional loop counter is enabled by defining CPU_CS_USEQ_LOOPCNT_EN.
module cpu_cs_useq_16 #(
    parameter int STACK_DEPTH = 5,
    parameter int LCNT_W      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ADV,
    input  logic [3:0]  INSTR_3_0,
    input  logic [12:0] D_12_0,
    input  logic        CC,
    input  logic        CCEN_n,
    output logic [12:0] CSA_12_0,
    output logic [9:0]  CSCA_9_0,
    output logic        STK_EMPTY,
    output logic        STK_FULL,
    output logic        STK_ERR,
    output logic        LCNT_ZERO
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [12:0]     csa, nxt, inc, tos;
    logic [12:0]     stk [STACK_DEPTH];
    logic [SP_W-1:0] sp, top_idx;
    logic            err, pass, empty, full;
    logic            push, pop, tos_rd, clr, err_set;

    assign pass    = CCEN_n | CC;
    assign inc     = csa + 13'd1;
    assign empty   = (sp == '0);
    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign top_idx = empty ? '0 : sp - 1'b1;
    // An empty stack reads as address zero.
    assign tos     = empty ? 13'd0 : stk[top_idx];
    assign err_set = (push & full) | ((pop | tos_rd) & empty);

`ifdef CPU_CS_USEQ_LOOPCNT_EN
    logic [LCNT_W-1:0] lcnt;
    logic              ld_cnt, dec_cnt;
`endif

    always_comb begin
        nxt    = inc;
        push   = 1'b0;
        pop    = 1'b0;
        tos_rd = 1'b0;
        clr    = 1'b0;
`ifdef CPU_CS_USEQ_LOOPCNT_EN
        ld_cnt  = 1'b0;
        dec_cnt = 1'b0;
`endif
        case (INSTR_3_0)
            4'h0: begin nxt = '0; clr = 1'b1; end
            4'h2: if (pass) nxt = D_12_0;
            4'h3: if (pass) begin push = 1'b1; nxt = D_12_0; end
            4'h4: if (pass) begin pop = 1'b1; nxt = tos; end
`ifdef CPU_CS_USEQ_LOOPCNT_EN
            4'h5: ld_cnt = 1'b1;
            4'h6: if (lcnt != '0) begin dec_cnt = 1'b1; nxt = D_12_0; end
`endif
            4'h7: push = 1'b1;
            // Loop end: exit on pass, otherwise branch back to the loop head.
            4'h8: if (pass) pop = 1'b1;
                  else begin tos_rd = 1'b1; nxt = tos; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            csa <= '0;
            sp  <= '0;
            err <= 1'b0;
        end else if (ADV) begin
            csa <= nxt;
            if (clr)                sp <= '0;
            else if (push && !full) sp <= sp + 1'b1;
            else if (pop && !empty) sp <= sp - 1'b1;
            if (clr)          err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

    // Entries above sp are don't-care, so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (ADV && push && !full && !clr) stk[sp] <= inc;
    end

`ifdef CPU_CS_USEQ_LOOPCNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          lcnt <= '0;
        else if (ADV) begin
            if (ld_cnt)       lcnt <= D_12_0[LCNT_W-1:0];
            else if (dec_cnt) lcnt <= lcnt - 1'b1;
        end
    end
    assign LCNT_ZERO = (lcnt == '0);
`else
    localparam int lcnt_w_unused = LCNT_W;
    assign LCNT_ZERO = 1'b1;
`endif

    assign CSA_12_0  = csa;
    assign CSCA_9_0  = tos[9:0];
    assign STK_EMPTY = empty;
    assign STK_FULL  = full;
    assign STK_ERR   = err;

endmodule

// File: tb/tb_cpu_cs_useq_16.sv
// Bench for cpu_cs_useq_16: queue-based sequencer model, per-cycle compare, directed + random stimulus.
module tb_cpu_cs_useq_16;

`ifdef CPU_CS_USEQ_LOOPCNT_EN
    localparam bit LCE = 1'b1;
`else
    localparam bit LCE = 1'b0;
`endif
    localparam int DEPTH = 5;

    logic        CLK = 1'b0, RST = 1'b1, ADV = 1'b0, CC = 1'b0, CCEN_n = 1'b0;
    logic [3:0]  INSTR_3_0 = 4'h1;
    logic [12:0] D_12_0 = '0;
    logic [12:0] CSA_12_0;
    logic [9:0]  CSCA_9_0;
    logic        STK_EMPTY, STK_FULL, STK_ERR, LCNT_ZERO;

    cpu_cs_useq_16 dut (
        .CLK(CLK), .RST(RST), .ADV(ADV), .INSTR_3_0(INSTR_3_0), .D_12_0(D_12_0),
        .CC(CC), .CCEN_n(CCEN_n), .CSA_12_0(CSA_12_0), .CSCA_9_0(CSCA_9_0),
        .STK_EMPTY(STK_EMPTY), .STK_FULL(STK_FULL), .STK_ERR(STK_ERR), .LCNT_ZERO(LCNT_ZERO)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model
    int          m_csa;
    int          m_stk[$];
    int          m_cnt;
    bit          m_err;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_csa = 0; m_stk.delete(); m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic mpush(input int v);
        if (m_stk.size() >= DEPTH) m_err = 1'b1;
        else m_stk.push_back(v);
    endtask

    task automatic mpop(output int v);
        if (m_stk.size() == 0) begin v = 0; m_err = 1'b1; end
        else v = m_stk.pop_back();
    endtask

    function automatic int mtos();
        return (m_stk.size() == 0) ? 0 : m_stk[$];
    endfunction

    task automatic mstep(input bit adv, input int ins, input int d, input bit cc, input bit ccen);
        bit pass;
        int inc, nxt, v;
        if (!adv) return;
        pass = ccen | cc;
        inc  = (m_csa + 1) % 8192;
        nxt  = inc;
        case (ins)
            0: begin nxt = 0; m_stk.delete(); m_err = 1'b0; end
            2: if (pass) nxt = d;
            3: if (pass) begin mpush(inc); nxt = d; end
            4: if (pass) begin mpop(v); nxt = v; end
            5: if (LCE) m_cnt = d % 256;
            6: if (LCE && m_cnt != 0) begin m_cnt--; nxt = d; end
            7: mpush(inc);
            8: if (pass) mpop(v);
               else begin
                   if (m_stk.size() == 0) m_err = 1'b1;
                   nxt = mtos();
               end
            default: ;
        endcase
        m_csa = nxt;
    endtask

    task automatic cyc(input bit adv, input int ins, input int d, input bit cc, input bit ccen);
        ADV = adv; INSTR_3_0 = 4'(ins); D_12_0 = 13'(d); CC = cc; CCEN_n = ccen;
        mstep(adv, ins, d, cc, ccen);
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("csa",   int'(CSA_12_0),  m_csa);
            check("csca",  int'(CSCA_9_0),  mtos() % 1024);
            check("empty", int'(STK_EMPTY), int'(m_stk.size() == 0));
            check("full",  int'(STK_FULL),  int'(m_stk.size() == DEPTH));
            check("err",   int'(STK_ERR),   int'(m_err));
            check("lzero", int'(LCNT_ZERO), int'(!LCE || m_cnt == 0));
        end
    end

    initial begin
        mreset();
        #12;
        check("rst_csa",   int'(CSA_12_0), 0);
        check("rst_csca",  int'(CSCA_9_0), 0);
        check("rst_empty", int'(STK_EMPTY), 1);
        check("rst_full",  int'(STK_FULL), 0);
        check("rst_err",   int'(STK_ERR), 0);
        check("rst_lzero", int'(LCNT_ZERO), 1);
        RST = 1'b0;
        chk_en = 1'b1;

        // Sequential advance and hold
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
        check("cont3", int'(CSA_12_0), 3);
        cyc(0, 2, 13'h1234, 1, 1);
        cyc(0, 0, 0, 0, 0);
        check("hold", int'(CSA_12_0), 3);

        // Subroutine call and return
        cyc(1, 2, 13'h0010, 1, 0);
        check("cjp", int'(CSA_12_0), 13'h0010);
        cyc(1, 3, 13'h0400, 0, 1);
        check("cjs_csa", int'(CSA_12_0), 13'h0400);
        check("cjs_csca", int'(CSCA_9_0), 10'h011);
        check("cjs_empty", int'(STK_EMPTY), 0);
        cyc(1, 4, 13'h0777, 1, 0);
        check("crtn_csa", int'(CSA_12_0), 13'h0011);
        check("crtn_empty", int'(STK_EMPTY), 1);

        // Loop counter
        cyc(1, 2, 13'h0020, 0, 1);
        cyc(1, 5, 3, 0, 0);
`ifdef CPU_CS_USEQ_LOOPCNT_EN
        check("ldct_lz", int'(LCNT_ZERO), 0);
        cyc(1, 6, 13'h0050, 0, 0); check("rpct1", int'(CSA_12_0), 13'h0050);
        cyc(1, 6, 13'h0050, 0, 0); check("rpct2", int'(CSA_12_0), 13'h0050);
        cyc(1, 6, 13'h0050, 0, 0); check("rpct3", int'(CSA_12_0), 13'h0050);
        check("rpct3_lz", int'(LCNT_ZERO), 1);
        cyc(1, 6, 13'h0050, 0, 0); check("rpct4", int'(CSA_12_0), 13'h0051);
`else
        check("ldct_cont", int'(CSA_12_0), 13'h0021);
        check("ldct_lz", int'(LCNT_ZERO), 1);
        for (int i = 0; i < 4; i++) cyc(1, 6, 13'h0050, 0, 0);
        check("rpct_cont", int'(CSA_12_0), 13'h0025);
`endif

        // Stack overflow / underflow
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 3, 13'h0100 + i, 1, 0);
            if (i == 4) begin
                check("full5", int'(STK_FULL), 1);
                check("err5", int'(STK_ERR), 0);
            end
        end
        check("err6", int'(STK_ERR), 1);
        check("ovf_csca", int'(CSCA_9_0), 10'h104);
        check("ovf_csa", int'(CSA_12_0), 13'h0105);
        for (int i = 0; i < 5; i++) cyc(1, 4, 0, 1, 1);
        check("pop_last", int'(CSA_12_0), 13'h0001);
        cyc(1, 4, 13'h0abc, 1, 0);
        check("udf_csa", int'(CSA_12_0), 0);
        check("udf_err", int'(STK_ERR), 1);
        cyc(1, 0, 0, 0, 0);
        check("jz_err", int'(STK_ERR), 0);

        // Wrap and condition gating
        cyc(1, 2, 13'h1fff, 0, 1);
        cyc(1, 1, 0, 0, 0);
        check("wrap", int'(CSA_12_0), 0);
        cyc(1, 2, 13'h0123, 0, 0);
        check("cjp_fail", int'(CSA_12_0), 1);
        cyc(1, 2, 13'h0123, 0, 1);
        check("cjp_ccen", int'(CSA_12_0), 13'h0123);

        // Asynchronous reset mid-loop with two entries stacked
        cyc(1, 7, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        cyc(1, 8, 0, 0, 0);
        check("loop_back", int'(CSA_12_0), 13'h0125);
        #2 RST = 1'b1;
        mreset();
        #1;
        check("arst_csa",   int'(CSA_12_0), 0);
        check("arst_csca",  int'(CSCA_9_0), 0);
        check("arst_empty", int'(STK_EMPTY), 1);
        check("arst_full",  int'(STK_FULL), 0);
        check("arst_err",   int'(STK_ERR), 0);
        check("arst_lzero", int'(LCNT_ZERO), 1);
        @(negedge CLK); #1;
        RST = 1'b0;
        cyc(1, 1, 0, 0, 0);
        check("post_rst", int'(CSA_12_0), 1);

        // Randomised traffic checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            int ins;
            ins = $urandom_range(0, 15);
            if (ins == 0 && $urandom_range(0, 3) != 0) ins = 3;
            cyc($urandom_range(0, 7) != 0, ins, $urandom_range(0, 8191),
                $urandom_range(0, 1), $urandom_range(0, 3) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
